// File: rtl/uart_tx_core_if.sv
// Host-side transmit holding register port of the UART transmitter.
// The host writes bytes and watches the two LSR empty flags.
interface uart_tx_core_if;
   logic [7:0] thr_data;
   logic       thr_wr;
   logic       thr_empty;
   logic       tsr_empty;

   modport master (output thr_data, thr_wr, input thr_empty, tsr_empty);
   modport slave  (input thr_data, thr_wr, output thr_empty, tsr_empty);
endinterface

// File: rtl/uart_tx_core.sv
// 8250-style UART transmitter: 16x baud generator from the edge-detected 1.8432 MHz
// clock, THR/TSR pair and a start/data/parity/stop serialiser, all in clk_50m.
module uart_tx_core (
   input  logic        clk_50m,
   input  logic        rst_n,
   input  logic        uart_clk_in,
   input  logic [15:0] divisor,
   input  logic [1:0]  lcr_wls,
   input  logic        lcr_stb,
   input  logic        lcr_pen,
   input  logic        lcr_eps,
   input  logic        lcr_brk,
   uart_tx_core_if.slave thr_bus,
   output logic        baud16,
   output logic        txd,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t      state, state_n;
   logic        uclk_d, uclk_en;
   logic [15:0] cnt;
   logic [7:0]  thr_q, thr_n, tsr, tsr_n, mask_n;
   logic        thr_empty_q, thr_empty_n, tsr_empty_q, tsr_empty_n;
   logic [3:0]  tick, tick_n;
   logic [2:0]  bit_cnt, bit_n;
   logic [1:0]  wls_l, wls_n;
   logic        stb_l, stb_n, pen_l, pen_n, par_l, par_n;
   logic        txd_q, txd_n, load, stop_done;

   assign uclk_en = uart_clk_in & ~uclk_d;

   // Divisor 0 reloads 0 without pulsing, so the generator stays parked.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         uclk_d <= 1'b0;
         cnt    <= 16'd0;
         baud16 <= 1'b0;
      end else begin
         uclk_d <= uart_clk_in;
         baud16 <= 1'b0;
         if (uclk_en) begin
            if (cnt <= 16'd1) begin
               cnt    <= divisor;
               baud16 <= (divisor != 16'd0);
            end else begin
               cnt <= cnt - 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         thr_q       <= 8'd0;
         thr_empty_q <= 1'b1;
         tsr_empty_q <= 1'b1;
         tsr         <= 8'd0;
         tick        <= 4'd0;
         bit_cnt     <= 3'd0;
         wls_l       <= 2'd0;
         stb_l       <= 1'b0;
         pen_l       <= 1'b0;
         par_l       <= 1'b0;
         txd_q       <= 1'b1;
      end else begin
         state       <= state_n;
         thr_q       <= thr_n;
         thr_empty_q <= thr_empty_n;
         tsr_empty_q <= tsr_empty_n;
         tsr         <= tsr_n;
         tick        <= tick_n;
         bit_cnt     <= bit_n;
         wls_l       <= wls_n;
         stb_l       <= stb_n;
         pen_l       <= pen_n;
         par_l       <= par_n;
         txd_q       <= txd_n;
      end
   end

   // Stop is 16 ticks, or a second segment of 8 (wls=0) or 16 ticks when stb is set.
   assign stop_done = !stb_l ? (tick == 4'd15)
                             : (bit_cnt[0] && ((wls_l == 2'd0) ? (tick == 4'd7) : (tick == 4'd15)));

   always_comb begin
      state_n = state;
      tick_n  = tick;
      bit_n   = bit_cnt;
      tsr_n   = tsr;
      wls_n   = wls_l;
      stb_n   = stb_l;
      pen_n   = pen_l;
      par_n   = par_l;
      load    = 1'b0;
      mask_n  = 8'hFF >> (2'd3 - lcr_wls);
      if (baud16) begin
         case (state)
            IDLE: load = !thr_empty_q;
            START: begin
               tick_n = tick + 4'd1;
               if (tick == 4'd15) begin
                  state_n = DATA;
                  bit_n   = 3'd0;
               end
            end
            DATA: begin
               tick_n = tick + 4'd1;
               if (tick == 4'd15) begin
                  tsr_n = tsr >> 1;
                  if (bit_cnt == 3'd4 + {1'b0, wls_l}) begin
                     state_n = pen_l ? PARITY : STOP;
                     bit_n   = 3'd0;
                  end else begin
                     bit_n = bit_cnt + 3'd1;
                  end
               end
            end
            PARITY: begin
               tick_n = tick + 4'd1;
               if (tick == 4'd15) begin
                  state_n = STOP;
                  bit_n   = 3'd0;
               end
            end
            STOP: begin
               tick_n = tick + 4'd1;
               if (tick == 4'd15) bit_n = bit_cnt + 3'd1;
               if (stop_done) begin
                  if (!thr_empty_q) begin
                     load = 1'b1;
                  end else begin
                     state_n = IDLE;
                     tick_n  = 4'd0;
                     bit_n   = 3'd0;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
      if (load) begin
         state_n = START;
         tick_n  = 4'd0;
         bit_n   = 3'd0;
         tsr_n   = thr_q;
         wls_n   = lcr_wls;
         stb_n   = lcr_stb;
         pen_n   = lcr_pen;
         par_n   = (^(thr_q & mask_n)) ^ ~lcr_eps;
      end
   end

   // A write in the transfer cycle wins: TSR takes the old byte, THR stays full.
   always_comb begin
      thr_n       = thr_bus.thr_wr ? thr_bus.thr_data : thr_q;
      thr_empty_n = thr_bus.thr_wr ? 1'b0 : (load ? 1'b1 : thr_empty_q);
      tsr_empty_n = (state_n == IDLE) & thr_empty_n;
      case (state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = tsr_n[0];
         PARITY:  txd_n = par_n;
         default: txd_n = 1'b1;
      endcase
   end

   assign thr_bus.thr_empty = thr_empty_q;
   assign thr_bus.tsr_empty = tsr_empty_q;
   assign txd               = txd_q & ~lcr_brk;
   assign state_dbg         = state;

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Transmit half of the 8250-style UART on the 8088 bus. It consumes the 1.8432 MHz UART clock produced by the 50 MHz fractional divider and applies the CPU-programmed 16-bit divisor latch to form a 16x baud enable. It serialises bytes from a transmit holding register (THR) through a transmit shift register (TSR) onto txd. Everything runs in the clk_50m domain; the 1.8432 MHz clock is treated as a level signal and edge-detected, never used as a clock.

Parameters:
none

Ports:
clk_50m      in   1   system clock, 50 MHz
rst_n        in   1   reset, asynchronous, active-low
uart_clk_in  in   1   1.8432 MHz clock from divider, registered in clk_50m domain
divisor      in   16  divisor latch {DLM,DLL}
lcr_wls      in   2   word length select: 0..3 = 5..8 data bits
lcr_stb      in   1   stop bits: 0 = 1; 1 = 2 (1.5 when wls=0)
lcr_pen      in   1   parity enable
lcr_eps      in   1   even parity select (1 = even)
lcr_brk      in   1   break control
thr_data     in   8   byte to transmit
thr_wr       in   1   one-cycle write strobe for THR
thr_empty    out  1   THR empty (LSR bit 5)
tsr_empty    out  1   THR and TSR both empty (LSR bit 6)
baud16       out  1   one-cycle 16x baud enable (BAUDOUT equivalent)
txd          out  1   serial output, idle high

Behaviour:
- Reset (async, rst_n low): txd=1, thr_empty=1, tsr_empty=1, baud16=0; FSM=IDLE; all counters 0; edge-detect register 0.
- Edge detect:
  - uclk_en = uart_clk_in & ~uclk_d; uclk_d is registered every cycle.
  - One pulse per 1.8432 MHz rising edge.
- Divisor counter (16-bit):
  - On uclk_en: if cnt<=1, reload cnt=divisor and pulse baud16 for one cycle; otherwise decrement cnt.
  - divisor=1: baud16 on every uclk_en.
  - divisor=0: no baud16 ever; cnt held at 0.
  - A divisor change takes effect at the next reload.
- THR:
  - thr_wr loads thr_data and sets thr_empty=0 on the next edge.
  - A write while thr_empty=0 overwrites the held byte.
- FSM states IDLE, START, DATA, PARITY, STOP. All state actions occur only on baud16 cycles. A 4-bit tick counter counts 16 baud16 ticks per bit.
  - IDLE: if thr_empty=0 on a baud16 cycle:
    - Copy THR to TSR.
    - Latch wls/stb/pen/eps for the whole character.
    - Set thr_empty=1 and tsr_empty=0; go to START.
  - START: txd=0 for 16 ticks, then DATA.
  - DATA: LSB first, 5+wls bits, 16 ticks each. Then PARITY if pen, else STOP.
  - PARITY: bit = XOR of the transmitted data bits only (bits above word length excluded), inverted when eps=0. Lasts 16 ticks.
  - STOP: txd=1 for 16, 32, or 24 ticks (24 when stb=1 and wls=0). Then IDLE.
    - tsr_empty returns to 1 only if thr_empty=1 at that point.
    - Otherwise the next START loads on the very next baud16 cycle, so there is no idle gap.
- Simultaneous thr_wr and THR->TSR transfer in the same cycle:
  - TSR takes the old byte.
  - THR takes the new byte and thr_empty stays 0.
- tsr_empty = (state==IDLE) & thr_empty, registered.
- Break: lcr_brk=1 forces txd=0 combinationally over the FSM output. The FSM keeps running, so flag timing is unchanged.
- txd is registered (glitch-free) except for the break override, which is ANDed with the registered value.
- Reset mid-frame aborts the character immediately. The pending THR byte is lost.

Test Plan:
- divisor=12, wls=3, pen=0, stb=0, write 0x55 -> txd 0,1,0,1,0,1,0,1,0,1. Each bit lasts 192 uclk_en pulses (~104.17 us, 9600 baud). thr_empty=1 at the first start-bit baud16 tick; tsr_empty=1 after 16 stop ticks.
- divisor=1, wls=0, pen=1, eps=1, stb=1, write 0x1F -> data 1,1,1,1,1; parity 1; stop high for exactly 24 baud16 ticks.
- divisor=1, write 0xA5, then write 0x3C as soon as thr_empty=1 -> second start bit begins on the first baud16 after the first stop. tsr_empty never rises between frames.
- write 0x11 then 0x22 with divisor=0 (no ticks), then set divisor=2 -> only 0x22 is transmitted. With divisor=0, txd stays 1 and thr_empty stays 0 indefinitely.
- lcr_brk=1 during DATA bit 3 -> txd=0 continuously. Release after 40 ticks -> frame ends at its original time; tsr_empty rises at the unchanged tick.
- rst_n low for 3 cycles mid-DATA -> txd=1, thr_empty=1, tsr_empty=1, baud16=0 within the same cycle (async). After release, no residual transmission occurs.
